// File: rtl/noc_buf_pkg.sv
// Shared types and helpers for the multi-channel NoC input buffer.
// Round-robin winner search is padded to 16 channels so callers need no channel count.
// Pure declarations: no latency, no backpressure.
package noc_buf_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int STAT_W = 16;
    localparam int RR_W   = 4;
    localparam int RR_N   = 1 << RR_W;

    // First eligible index strictly after 'last', wrapping; ineligible padding never wins.
    function automatic logic [RR_W-1:0] next_rr(input logic [RR_N-1:0] eligible,
                                                input logic [RR_W-1:0] last);
        logic [RR_W-1:0] idx;
        logic            found;
        next_rr = last;
        found   = 1'b0;
        for (int i = 1; i <= RR_N; i++) begin
            idx = last + RR_W'(i);
            if (!found && eligible[idx]) begin
                next_rr = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Single-channel first-word-fall-through FIFO that also counts complete packets held.
// Latency: a written word is visible at the head the cycle after the write.
// Backpressure: push is ignored while full, pop is ignored while empty.
module noc_pkt_fifo
    import noc_buf_pkg::*;
#(
    parameter int W      = 37,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    push_dat,
    input  logic            pop,
    output logic [W-1:0]    head_dat,
    output logic            empty,
    output logic            full,
    output logic [ADDR_W:0] occ,
    output logic [ADDR_W:0] pkt_cnt
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_OCC = DEPTH;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr;
    logic              rd;
    logic              last_in;
    logic              last_out;

    assign full     = (occ == FULL_OCC);
    assign empty    = (occ == '0);
    assign head_dat = mem[rd_ptr];
    assign wr       = push & ~full;
    assign rd       = pop & ~empty;
    assign last_in  = wr & push_dat[W-1];
    assign last_out = rd & head_dat[W-1];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr, rd})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
            case ({last_in, last_out})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: rtl/noc_buffer_in_mc.sv
// Per-channel packet FIFOs merged onto one stream with packet-granular round-robin; optional NOC_BUF_STATS_EN stats.
// Latency: first beat valid one cycle after a packet becomes eligible; one idle bubble between packets.
// Backpressure: per-channel TREADY drops when that FIFO is full; output holds its head until TREADY.
module noc_buffer_in_mc
    import noc_buf_pkg::*;
#(
    parameter int BW       = 32,
    parameter int BWB      = BW / 8,
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 5,
    parameter int PKT_MODE = 1,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_in,
    input  logic                  clk_in_rst_high,
    input  logic [NUM_CH-1:0]     stream_in_TVALID,
    input  logic [NUM_CH*BW-1:0]  stream_in_TDATA,
    input  logic [NUM_CH*BWB-1:0] stream_in_TKEEP,
    input  logic [NUM_CH-1:0]     stream_in_TLAST,
    output logic [NUM_CH-1:0]     stream_in_TREADY,
    output logic                  stream_out_TVALID,
    output logic [BW-1:0]         stream_out_TDATA,
    output logic [BWB-1:0]        stream_out_TKEEP,
    output logic                  stream_out_TLAST,
    output logic [CH_W-1:0]       stream_out_TDEST,
    input  logic                  stream_out_TREADY
`ifdef NOC_BUF_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [NUM_CH*STAT_W-1:0]     stat_pkt_cnt,
    output logic [NUM_CH*(ADDR_W+1)-1:0] stat_max_occ
`endif
);

    localparam int W = BW + BWB + 1;

    logic              rst;
    logic [W-1:0]      head_dat [NUM_CH];
    logic [ADDR_W:0]   occ      [NUM_CH];
    logic [ADDR_W:0]   pkt_cnt  [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] push_vld;
    logic [NUM_CH-1:0] pop_vld;

    arb_state_t        state, state_nxt;
    logic [CH_W-1:0]   gnt, gnt_nxt;
    logic [CH_W-1:0]   last_gnt, last_gnt_nxt;
    logic [W-1:0]      cur_dat;
    logic              out_vld;

    assign rst              = clk_in_rst_high;
    assign stream_in_TREADY = ~full & {NUM_CH{~rst}};
    assign push_vld         = stream_in_TVALID & stream_in_TREADY;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        noc_pkt_fifo #(
            .W      (W),
            .ADDR_W (ADDR_W)
        ) u_fifo (
            .clk      (clk_in),
            .rst      (rst),
            .push     (push_vld[c]),
            .push_dat ({stream_in_TLAST[c], stream_in_TKEEP[c*BWB +: BWB], stream_in_TDATA[c*BW +: BW]}),
            .pop      (pop_vld[c]),
            .head_dat (head_dat[c]),
            .empty    (empty[c]),
            .full     (full[c]),
            .occ      (occ[c]),
            .pkt_cnt  (pkt_cnt[c])
        );

        // A full FIFO must be released even without TLAST, or an over-long packet deadlocks.
        if (PKT_MODE != 0) begin : g_saf
            assign eligible[c] = (pkt_cnt[c] != '0) | full[c];
        end else begin : g_ct
            assign eligible[c] = ~empty[c];
        end
    end

    assign cur_dat = head_dat[gnt];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= CH_W'(NUM_CH - 1);
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_gnt_nxt = last_gnt;
        out_vld      = 1'b0;
        pop_vld      = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    gnt_nxt   = CH_W'(next_rr(RR_N'(eligible), RR_W'(last_gnt)));
                    state_nxt = XFER;
                end
            end
            XFER: begin
                out_vld = ~empty[gnt] & ~rst;
                if (out_vld && stream_out_TREADY) begin
                    pop_vld[gnt] = 1'b1;
                    if (cur_dat[W-1]) begin
                        state_nxt    = IDLE;
                        last_gnt_nxt = gnt;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stream_out_TVALID = out_vld;
    assign stream_out_TDATA  = cur_dat[BW-1:0];
    assign stream_out_TKEEP  = cur_dat[BW +: BWB];
    assign stream_out_TLAST  = out_vld & cur_dat[W-1];
    assign stream_out_TDEST  = rst ? '0 : gnt;

`ifdef NOC_BUF_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_ONE = 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        logic [STAT_W-1:0] pkt_stat;
        logic [ADDR_W:0]   max_occ;

        always_ff @(posedge clk_in) begin
            if (rst || stat_clr) begin
                pkt_stat <= '0;
                max_occ  <= '0;
            end else begin
                if (pop_vld[c] && head_dat[c][W-1] && pkt_stat != STAT_MAX) begin
                    pkt_stat <= pkt_stat + STAT_ONE;
                end
                if (occ[c] > max_occ) begin
                    max_occ <= occ[c];
                end
            end
        end

        assign stat_pkt_cnt[c*STAT_W +: STAT_W]         = pkt_stat;
        assign stat_max_occ[c*(ADDR_W+1) +: (ADDR_W+1)] = max_occ;
    end
`else
    logic [NUM_CH-1:0] occ_unused;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_nostat
        assign occ_unused[c] = ^occ[c];
    end
`endif

endmodule

// File: tb/tb_noc_buffer_in_mc.sv
// Scoreboard bench for noc_buffer_in_mc (depth-4 FIFOs, store-and-forward).
`timescale 1ns/1ps
module tb_noc_buffer_in_mc;

    localparam int BW     = 32;
    localparam int BWB    = 4;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 2;
    localparam int CH_W   = 2;
    localparam int BTW    = BW + BWB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  ch_vld  [NUM_CH];
    logic [BW-1:0]         ch_dat  [NUM_CH];
    logic [BWB-1:0]        ch_keep [NUM_CH];
    logic                  ch_last [NUM_CH];

    logic [NUM_CH-1:0]     in_vld;
    logic [NUM_CH*BW-1:0]  in_dat;
    logic [NUM_CH*BWB-1:0] in_keep;
    logic [NUM_CH-1:0]     in_last;
    logic [NUM_CH-1:0]     in_rdy;
    logic                  out_vld;
    logic [BW-1:0]         out_dat;
    logic [BWB-1:0]        out_keep;
    logic                  out_last;
    logic [CH_W-1:0]       out_dest;
    logic                  out_rdy = 1'b1;

`ifdef NOC_BUF_STATS_EN
    logic                          stat_clr = 1'b0;
    logic [NUM_CH*16-1:0]          stat_pkt_cnt;
    logic [NUM_CH*(ADDR_W+1)-1:0]  stat_max_occ;
`endif

    always_comb begin
        in_vld  = '0;
        in_dat  = '0;
        in_keep = '0;
        in_last = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_vld[c]              = ch_vld[c];
            in_dat[c*BW +: BW]     = ch_dat[c];
            in_keep[c*BWB +: BWB]  = ch_keep[c];
            in_last[c]             = ch_last[c];
        end
    end

    noc_buffer_in_mc #(
        .BW       (BW),
        .BWB      (BWB),
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .PKT_MODE (1),
        .CH_W     (CH_W)
    ) dut (
        .clk_in            (clk),
        .clk_in_rst_high   (rst),
        .stream_in_TVALID  (in_vld),
        .stream_in_TDATA   (in_dat),
        .stream_in_TKEEP   (in_keep),
        .stream_in_TLAST   (in_last),
        .stream_in_TREADY  (in_rdy),
        .stream_out_TVALID (out_vld),
        .stream_out_TDATA  (out_dat),
        .stream_out_TKEEP  (out_keep),
        .stream_out_TLAST  (out_last),
        .stream_out_TDEST  (out_dest),
        .stream_out_TREADY (out_rdy)
`ifdef NOC_BUF_STATS_EN
        ,
        .stat_clr          (stat_clr),
        .stat_pkt_cnt      (stat_pkt_cnt),
        .stat_max_occ      (stat_max_occ)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [BTW-1:0] exp_q [NUM_CH][$];
    int             exp_dest_q[$];
    int             hs_log[$];
    bit             log_en  = 1'b0;
    bit             rand_on = 1'b0;
    bit             t4_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the per-channel expectation on every output handshake.
    initial begin : monitor
        bit             in_pkt;
        logic [CH_W-1:0] cur_dest;
        logic [BTW-1:0] e;
        int             d;
        in_pkt   = 1'b0;
        cur_dest = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pkt = 1'b0;
            end else if (out_vld && out_rdy) begin
                if (log_en) hs_log.push_back(cyc);
                if (!in_pkt) begin
                    if (exp_dest_q.size() > 0) begin
                        d = exp_dest_q.pop_front();
                        check("pkt_order", 64'(out_dest), 64'(d));
                    end
                    cur_dest = out_dest;
                    in_pkt   = 1'b1;
                end else begin
                    check("tdest_stable", 64'(out_dest), 64'(cur_dest));
                end
                if (exp_q[out_dest].size() == 0) begin
                    check("unexpected_beat", 64'({out_last, out_keep, out_dat}), 64'(0));
                end else begin
                    e = exp_q[out_dest].pop_front();
                    check("beat", 64'({out_last, out_keep, out_dat}), 64'(e));
                end
                if (out_last) in_pkt = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input int c, input logic [BW-1:0] d, input logic [BWB-1:0] k, input logic l);
        bit ok;
        ok         = 1'b0;
        ch_vld[c]  = 1'b1;
        ch_dat[c]  = d;
        ch_keep[c] = k;
        ch_last[c] = l;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (in_rdy[c]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        ch_vld[c]  = 1'b0;
        ch_last[c] = 1'b0;
        if (ok) exp_q[c].push_back({l, k, d});
        else check("send_timeout", 64'(ok), 64'(1));
    endtask

    task automatic send_pkt(input int c, input int len, input logic [BW-1:0] base);
        for (int b = 0; b < len; b++) begin
            send_beat(c, base + BW'(b), 4'hF, b == len - 1);
        end
    endtask

    task automatic rand_driver(input int c);
        int len;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                send_beat(c, {8'(c), 8'(p), 8'(b), 8'h5A}, 4'($urandom_range(0, 15)), b == len - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        int pending;
        done = 1'b0;
        for (int t = 0; t < 5000 && !done; t++) begin
            @(negedge clk);
            pending = 0;
            for (int c = 0; c < NUM_CH; c++) pending += exp_q[c].size();
            if (pending == 0 && !out_vld) done = 1'b1;
        end
        check(name, 64'(done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit seen;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_vld[c]  = 1'b0;
            ch_dat[c]  = '0;
            ch_keep[c] = '0;
            ch_last[c] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_rdy), 64'(0));
        check("rst_out_valid", 64'(out_vld), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_dest", 64'(out_dest), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_rdy), 64'hF);
        @(posedge clk);
        #1;

        // Single-beat packets on all channels in one cycle: ch0..ch3, one bubble apart
        hs_log.delete();
        log_en = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_vld[c]  = 1'b1;
            ch_dat[c]  = 32'h100 + 32'(c);
            ch_keep[c] = 4'hF;
            ch_last[c] = 1'b1;
            exp_dest_q.push_back(c);
        end
        @(negedge clk);
        check("multi_accept", 64'(in_rdy), 64'hF);
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_vld[c]  = 1'b0;
            ch_last[c] = 1'b0;
            exp_q[c].push_back({1'b1, 4'hF, 32'h100 + 32'(c)});
        end
        wait_drain("drain_multi");
        log_en = 1'b0;
        check("multi_hs_count", 64'(hs_log.size()), 64'(4));
        if (hs_log.size() == 4) begin
            for (int i = 1; i < 4; i++) check("multi_bubble", 64'(hs_log[i] - hs_log[i-1]), 64'(2));
        end

        // 4-beat packet on ch2: valid exactly one cycle after the TLAST accept
        exp_dest_q.push_back(2);
        send_pkt(2, 4, 32'hA0);
        @(negedge clk);
        check("lat_ch2_pre", 64'(out_vld), 64'(0));
        @(negedge clk);
        check("lat_ch2_vld", 64'(out_vld), 64'(1));
        check("lat_ch2_first", 64'(out_dat), 64'hA0);
        wait_drain("drain_ch2");

        // Store-and-forward: no output until TLAST arrives
        exp_dest_q.push_back(1);
        for (int b = 0; b < 3; b++) send_beat(1, 32'hB0 + 32'(b), 4'hF, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_vld) seen = 1'b1;
        end
        check("saf_hold", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        send_beat(1, 32'hB3, 4'h3, 1'b1);
        @(negedge clk);
        check("saf_lat_pre", 64'(out_vld), 64'(0));
        @(negedge clk);
        check("saf_lat_vld", 64'(out_vld), 64'(1));
        check("saf_first", 64'(out_dat), 64'hB0);
        wait_drain("drain_saf");

        // Over-long packet on ch0 with output stalled: full-release grant
        out_rdy = 1'b0;
        exp_dest_q.push_back(0);
        fork
            begin
                send_pkt(0, 6, 32'hC0);
                t4_done = 1'b1;
            end
        join_none
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        check("full_accepts", 64'(exp_q[0].size()), 64'(4));
        check("full_ready_low", 64'(in_rdy[0]), 64'(0));
        check("full_release_vld", 64'(out_vld), 64'(1));
        check("full_release_dest", 64'(out_dest), 64'(0));
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        for (int t = 0; t < 200 && !t4_done; t++) @(posedge clk);
        #1;
        check("full_sender_done", 64'(t4_done), 64'(1));
        wait_drain("drain_full");

        // Random backpressure, 100 random-length packets across all channels
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join_none
        fork
            rand_driver(0);
            rand_driver(1);
            rand_driver(2);
            rand_driver(3);
        join
        rand_on = 1'b0;
        @(posedge clk);
        #2;
        out_rdy = 1'b1;
        wait_drain("drain_random");

        // Reset with a complete packet and a partial one buffered on ch3
        out_rdy = 1'b0;
        send_pkt(3, 2, 32'hD0);
        send_beat(3, 32'hD2, 4'hF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_vld", 64'(out_vld), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_vld", 64'(out_vld), 64'(0));
        check("midrst_ready", 64'(in_rdy), 64'(0));
        check("midrst_dest", 64'(out_dest), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_vld2", 64'(out_vld), 64'(0));
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        exp_dest_q.delete();
        rst     = 1'b0;
        out_rdy = 1'b1;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_vld) seen = 1'b1;
        end
        check("no_stale", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        exp_dest_q.push_back(3);
        send_pkt(3, 3, 32'hE0);
        wait_drain("drain_after_rst");
        check("order_queue_empty", 64'(exp_dest_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
